unidade_busca: RTL

Instruction-fetch unit of the single-issue RV32 subset core (ADD, OR, SLL, ADDI, LH, SH, BNE). Owns the program counter and drives the word address into `memoria_instrucoes`. Produces the PC and a valid flag aligned with the instruction that memory registers one cycle later. Handles sequential advance, stall bubbles, BNE redirects with wrong-path squash, end-of-program and misaligned-target halt.

---
 rtl/unidade_busca.sv | 134 +++++++++++++
 1 files changed

// File: rtl/unidade_busca.sv
// unidade_busca: instruction-fetch unit for the RV32 subset core.
// Owns the program counter, presents the word address to instruction memory
// and tracks the PC/valid flag of the instruction memory registers one cycle
// later. Handles stall bubbles, taken-BNE redirects with wrong-path squash,
// end-of-program and misaligned-target halts.
// Optional feature macro: CONTADOR_BUSCA_EN (saturating issued-instruction
// counter on contador_buscas; when undefined the port is tied to zero).
//
// state  | meaning
// INICIO | one idle cycle after reset, nothing issued
// BUSCA  | fetching: issue, stall, redirect or detect end of program
// FIM    | end of program reached, frozen until reset
// ERRO   | redirect target misaligned, frozen until reset
module unidade_busca #(
  parameter logic [31:0] PC_INICIAL = 32'h0000_0000,
  parameter int          NUM_INSTR  = 50
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        parar,
  input  logic        desvio_tomado,
  input  logic [31:0] pc_desvio,
  input  logic [11:0] imediato,
  output logic [31:0] endereco,
  output logic [31:0] pc_instr,
  output logic        valido,
  output logic        fim,
  output logic        erro_alinhamento,
  output logic [31:0] contador_buscas
);

  typedef enum logic [1:0] {
    INICIO = 2'd0,
    BUSCA  = 2'd1,
    FIM    = 2'd2,
    ERRO   = 2'd3
  } estado_t;

  localparam logic [29:0] LIMITE_PALAVRAS = 30'(NUM_INSTR);

  estado_t     estado_q, estado_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_instr_q, pc_instr_d;
  logic        valido_q, valido_d;
  logic        fim_q, fim_d;
  logic        erro_q, erro_d;

  logic [31:0] alvo;
  logic        fim_alcancado;

  // Branch target: offset field is in half-words, so append a zero LSB.
  assign alvo          = pc_desvio + {{19{imediato[11]}}, imediato, 1'b0};
  assign fim_alcancado = (pc_q[31:2] >= LIMITE_PALAVRAS);

  // State and fetch registers; reset clears everything immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= INICIO;
      pc_q       <= PC_INICIAL;
      pc_instr_q <= '0;
      valido_q   <= 1'b0;
      fim_q      <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      pc_q       <= pc_d;
      pc_instr_q <= pc_instr_d;
      valido_q   <= valido_d;
      fim_q      <= fim_d;
      erro_q     <= erro_d;
    end
  end

  // Next-state logic: redirect beats end-of-program beats stall beats issue.
  always_comb begin
    estado_d   = estado_q;
    pc_d       = pc_q;
    pc_instr_d = pc_instr_q;
    valido_d   = 1'b0;
    fim_d      = fim_q;
    erro_d     = erro_q;
    unique case (estado_q)
      INICIO: estado_d = BUSCA;
      BUSCA: begin
        if (desvio_tomado) begin
          if (alvo[1:0] == 2'b00) begin
            pc_d = alvo;
          end else begin
            erro_d   = 1'b1;
            estado_d = ERRO;
          end
        end else if (fim_alcancado) begin
          fim_d    = 1'b1;
          estado_d = FIM;
        end else if (!parar) begin
          pc_instr_d = pc_q;
          pc_d       = pc_q + 32'd4;
          valido_d   = 1'b1;
        end
      end
      FIM:  estado_d = FIM;
      ERRO: estado_d = ERRO;
      default: estado_d = INICIO;
    endcase
  end

  assign endereco         = {2'b00, pc_q[31:2]};
  assign pc_instr         = pc_instr_q;
  assign valido           = valido_q;
  assign fim              = fim_q;
  assign erro_alinhamento = erro_q;

`ifdef CONTADOR_BUSCA_EN
  logic [31:0] contador_q;
  logic        emite;

  // Same condition as the issue branch of the next-state logic.
  assign emite = (estado_q == BUSCA) && !desvio_tomado && !fim_alcancado && !parar;

  // Saturating issue counter, kept through FIM/ERRO, cleared only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      contador_q <= '0;
    end else if (emite && (contador_q != 32'hFFFF_FFFF)) begin
      contador_q <= contador_q + 32'd1;
    end
  end

  assign contador_buscas = contador_q;
`else
  assign contador_buscas = '0;
`endif

endmodule
